// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the uart_tx_port slice: register map, STATUS bit layout
// and serializer state encodings. The PARITY state exists only with UART_TX_PARITY_EN.
package uart_tx_port_pkg;

    localparam logic [31:0] UART_BASE       = 32'h3000_0000;
    localparam logic [31:0] UART_DATA_OFF   = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFF = 32'h0000_0004;

    localparam int ST_FULL_BIT    = 0;
    localparam int ST_EMPTY_BIT   = 1;
    localparam int ST_BUSY_BIT    = 2;
    localparam int ST_OVERRUN_BIT = 3;
    localparam int ST_COUNT_LSB   = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with show-ahead read data. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module uart_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [7:0]                    din,
    output logic [7:0]                    dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // A pop frees a slot in the same cycle, so a push to a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/overrun, serializer FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 104,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  write_enable,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        busy,
    output tx_state_e   state_dbg
);

    localparam int unsigned BW = $clog2(CLK_DIV);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Bus protocol: a cycle with en high is a transfer; any write_enable bit makes
    // it a store, otherwise a load whose data appears on data_out after the edge.
    // There is no stall, so every transfer completes in the cycle it is presented.
    logic        wr_req;
    logic        rd_req;
    logic        push_req;
    logic        status_rd;
    logic        push_drop;
    logic        overrun;
    logic [31:0] status_word;
    logic        unused_bits;

    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;

    tx_state_e   state;
    tx_state_e   state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        baud_last;
    logic        load;
    logic        shift;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    assign unused_bits = ^{addr[31:3], addr[1:0], data_in[31:8]};

    assign wr_req    = en && (write_enable != 3'b000);
    assign rd_req    = en && (write_enable == 3'b000);
    assign push_req  = wr_req && (addr[2] == UART_DATA_OFF[2]);
    assign status_rd = rd_req && (addr[2] == UART_STATUS_OFF[2]);
    assign push_drop = push_req && fifo_full && !fifo_pop;

    uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (data_in[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_word = '0;
        status_word[ST_COUNT_LSB +: 8] = 8'(fifo_count);
        status_word[ST_OVERRUN_BIT]    = overrun;
        status_word[ST_BUSY_BIT]       = busy;
        status_word[ST_EMPTY_BIT]      = fifo_empty;
        status_word[ST_FULL_BIT]       = fifo_full;
    end

    // A drop in the same cycle as a STATUS read wins, so the new overrun is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun  <= 1'b0;
            data_out <= '0;
        end else begin
            if (push_drop)      overrun <= 1'b1;
            else if (status_rd) overrun <= 1'b0;
            if (rd_req) data_out <= status_rd ? status_word : 32'h0;
        end
    end

    assign baud_last = (baud_cnt == BW'(CLK_DIV - 1));

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load       = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift = 1'b1;
`ifdef UART_TX_PARITY_EN
                    if (bit_cnt == 3'd7) state_next = ST_PARITY;
`else
                    if (bit_cnt == 3'd7) state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (baud_last) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load       = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || baud_last || state == ST_IDLE) baud_cnt <= '0;
            else                                                     baud_cnt <= baud_cnt + BW'(1);
            if (load)       shreg <= fifo_dout;
            else if (shift) shreg <= {1'b0, shreg[7:1]};
            if (shift) bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)       parity_bit <= 1'b0;
        else if (load) parity_bit <= ^fifo_dout;
    end
`endif

    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = parity_bit;
`endif
            default:   tx = 1'b1;
        endcase
    end

    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign state_dbg = state;

endmodule
